decode_queue_stage: RTL and testbench

// - Buffered, registered instruction decode stage for the single-stage core's successor pipeline.
// - Accepts raw 32-bit instructions into a FIFO via a valid/ready handshake.
// - Decodes the FIFO head with the isa_defs_pkg field extractors and opcode map.
// - Presents the decoded bundle from an output register under a second valid/ready handshake.
// - Optionally drops NOPs and optionally traps illegal opcodes.

---
 rtl/decode_queue_stage.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_decode_queue_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_stage.sv
// -----------------------------------------------------------------------------
// isa_defs_pkg / decode_queue_stage
//
// Purpose
//   Buffered, registered instruction decode stage. Raw 32-bit instructions are
//   accepted into a FIFO through a valid/ready handshake. The FIFO head is
//   decoded combinationally, and the decoded bundle is presented from an output
//   register under a second valid/ready handshake. NOPs can be dropped, and
//   unknown opcodes can be trapped.
//
// Instruction encoding (isa_defs_pkg)
//   [31:26] opcode   [25:21] rs1   [20:16] rs2 / I-type rd
//   [15:11] R-type rd               [15:0]  I-type immediate (signed)
//
// Parameters
//   FIFO_DEPTH  instruction FIFO entries; must be a power of 2 and >= 2
//   DROP_NOP    1: NOP-class heads are popped and never presented
//
// Configuration
//   DECODE_QUEUE_ILLEGAL_TRAP_EN  when defined, unknown opcodes are presented
//   with out_illegal=1 and set illegal_sticky on transfer. When undefined,
//   unknown opcodes are treated as NOPs and both trap outputs are tied to 0.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   flush                     synchronous flush: empties FIFO, clears out_valid
//   in_valid/in_ready/in_instr    upstream instruction handshake
//   out_valid/out_ready           downstream bundle handshake
//   out_is_rtype .. out_imm16     decoded bundle fields
//   out_illegal, illegal_sticky   trap outputs
//   fifo_count                    current FIFO occupancy
// -----------------------------------------------------------------------------
package isa_defs_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 6;
  localparam int REG_ADDR_W = 5;
  localparam int IMM_W      = 16;

  typedef enum logic [1:0] {
    ALU_OP_NOP = 2'd0,
    ALU_OP_ADD = 2'd1,
    ALU_OP_SUB = 2'd2
  } alu_op_e;

  localparam logic [OPCODE_W-1:0] OPC_NOP   = 6'h00;
  localparam logic [OPCODE_W-1:0] OPC_ADD   = 6'h01;
  localparam logic [OPCODE_W-1:0] OPC_SUB   = 6'h02;
  localparam logic [OPCODE_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 6'h10;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 6'h11;

  typedef struct packed {
    logic                         is_rtype;
    logic                         is_itype;
    alu_op_e                      alu_op;
    logic                         reg_write_en;
    logic                         mem_read;
    logic                         mem_write;
    logic [REG_ADDR_W-1:0]        rd_addr;
    logic [REG_ADDR_W-1:0]        rs1_addr;
    logic [REG_ADDR_W-1:0]        rs2_addr;
    logic signed [IMM_W-1:0]      imm16;
    logic                         illegal;
  } bundle_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] get_rs1(input logic [INSTR_W-1:0] instr);
    return instr[25:21];
  endfunction

  // Doubles as the destination field for I-type instructions.
  function automatic logic [REG_ADDR_W-1:0] get_rs2(input logic [INSTR_W-1:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] get_rd_r(input logic [INSTR_W-1:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic signed [IMM_W-1:0] get_imm16(input logic [INSTR_W-1:0] instr);
    return instr[15:0];
  endfunction

endpackage

module decode_queue_stage
  import isa_defs_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_NOP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_rtype,
  output logic                         out_is_itype,
  output alu_op_e                      out_alu_op,
  output logic                         out_reg_write_en,
  output logic                         out_mem_read,
  output logic                         out_mem_write,
  output logic [REG_ADDR_W-1:0]        out_rd_addr,
  output logic [REG_ADDR_W-1:0]        out_rs1_addr,
  output logic [REG_ADDR_W-1:0]        out_rs2_addr,
  output logic signed [IMM_W-1:0]      out_imm16,
  output logic                         out_illegal,
  output logic                         illegal_sticky,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam bit DROP_EN = (DROP_NOP != 0);

`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [INSTR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               out_valid_q, out_valid_d;
  bundle_t            bundle_q, bundle_d;

  logic [INSTR_W-1:0] head_instr;
  bundle_t            head_dec;
  logic               head_is_nop;
  logic               head_is_unknown;
  logic               head_drop;
  logic               push;
  logic               ld;

  // Ready depends on registered occupancy only: a full FIFO refuses input even
  // in a cycle where it is also popping, which keeps in_ready off the
  // out_ready path.
  assign in_ready = (count_q != DEPTH_C);
  assign push     = in_valid && in_ready;
  assign ld       = (count_q != '0) && (!out_valid_q || out_ready);

  assign head_instr = fifo_mem[rd_ptr_q];

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    head_dec          = '0;
    head_dec.alu_op   = ALU_OP_NOP;
    head_dec.rs1_addr = get_rs1(head_instr);
    head_dec.rs2_addr = get_rs2(head_instr);
    head_dec.rd_addr  = get_rs2(head_instr);
    head_dec.imm16    = get_imm16(head_instr);
    head_is_nop       = 1'b0;
    head_is_unknown   = 1'b0;
    unique case (get_opcode(head_instr))
      OPC_NOP: head_is_nop = 1'b1;
      OPC_ADD, OPC_SUB: begin
        head_dec.is_rtype     = 1'b1;
        head_dec.alu_op       = (get_opcode(head_instr) == OPC_ADD) ? ALU_OP_ADD : ALU_OP_SUB;
        head_dec.reg_write_en = 1'b1;
        head_dec.rd_addr      = get_rd_r(head_instr);
      end
      OPC_ADDI: begin
        head_dec.is_itype     = 1'b1;
        head_dec.alu_op       = ALU_OP_ADD;
        head_dec.reg_write_en = 1'b1;
      end
      // Memory ops carry no ALU operation; address generation happens in the
      // memory stage from rs1 and imm16.
      OPC_LOAD: begin
        head_dec.is_itype     = 1'b1;
        head_dec.mem_read     = 1'b1;
        head_dec.reg_write_en = 1'b1;
      end
      OPC_STORE: begin
        head_dec.is_itype  = 1'b1;
        head_dec.mem_write = 1'b1;
      end
      default: head_is_unknown = 1'b1;
    endcase
    head_dec.illegal = head_is_unknown && TRAP_EN;
  end

  // Without the trap, an unknown opcode is indistinguishable from a NOP.
  assign head_drop = DROP_EN && (head_is_nop || (head_is_unknown && !TRAP_EN));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (ld) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (head_drop) begin
          // ld implies the output is either empty or being consumed now, so a
          // dropped head always leaves the output register empty.
          out_valid_d = 1'b0;
        end else begin
          bundle_d    = head_dec;
          out_valid_d = 1'b1;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      unique case ({push, ld})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_valid_q     <= 1'b0;
      bundle_q        <= '0;
      bundle_q.alu_op <= ALU_OP_NOP;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr_q] <= in_instr;
  end

`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
  logic sticky_q;

  // Sets when an illegal bundle is actually handed downstream; flush leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (out_valid_q && out_ready && bundle_q.illegal) begin
      sticky_q <= 1'b1;
    end
  end

  assign illegal_sticky = sticky_q;
`else
  assign illegal_sticky = 1'b0;
`endif

  assign fifo_count       = count_q;
  assign out_valid        = out_valid_q;
  assign out_is_rtype     = bundle_q.is_rtype;
  assign out_is_itype     = bundle_q.is_itype;
  assign out_alu_op       = bundle_q.alu_op;
  assign out_reg_write_en = bundle_q.reg_write_en;
  assign out_mem_read     = bundle_q.mem_read;
  assign out_mem_write    = bundle_q.mem_write;
  assign out_rd_addr      = bundle_q.rd_addr;
  assign out_rs1_addr     = bundle_q.rs1_addr;
  assign out_rs2_addr     = bundle_q.rs2_addr;
  assign out_imm16        = bundle_q.imm16;
  assign out_illegal      = bundle_q.illegal;

endmodule

// File: tb/tb_decode_queue_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_queue_stage
//
// Two instances share all inputs: dut0 (DROP_NOP=1) and dut1 (DROP_NOP=0).
// A table of single-instruction decode vectors is followed by hand-written
// sequences for latency, fill/stall/wrap, NOP dropping, flush, the illegal
// opcode path and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_decode_queue_stage;
  import isa_defs_pkg::*;

`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready0, out_valid0, rt0, it0, wr0, mr0, mw0, ill0, sticky0;
  alu_op_e     alu0;
  logic [4:0]  rd0, rs10, rs20;
  logic [15:0] imm0;
  logic [2:0]  count0;

  logic        in_ready1, out_valid1, rt1, it1, wr1, mr1, mw1, ill1, sticky1;
  alu_op_e     alu1;
  logic [4:0]  rd1, rs11, rs21;
  logic [15:0] imm1;
  logic [2:0]  count1;

  logic [38:0] bun0, bun1;
  assign bun0 = {rt0, it0, alu0, wr0, mr0, mw0, rd0, rs10, rs20, imm0, ill0};
  assign bun1 = {rt1, it1, alu1, wr1, mr1, mw1, rd1, rs11, rs21, imm1, ill1};

  decode_queue_stage #(.FIFO_DEPTH(4), .DROP_NOP(1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_is_rtype(rt0), .out_is_itype(it0), .out_alu_op(alu0),
    .out_reg_write_en(wr0), .out_mem_read(mr0), .out_mem_write(mw0),
    .out_rd_addr(rd0), .out_rs1_addr(rs10), .out_rs2_addr(rs20),
    .out_imm16(imm0), .out_illegal(ill0), .illegal_sticky(sticky0),
    .fifo_count(count0)
  );

  decode_queue_stage #(.FIFO_DEPTH(4), .DROP_NOP(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_is_rtype(rt1), .out_is_itype(it1), .out_alu_op(alu1),
    .out_reg_write_en(wr1), .out_mem_read(mr1), .out_mem_write(mw1),
    .out_rd_addr(rd1), .out_rs1_addr(rs11), .out_rs2_addr(rs21),
    .out_imm16(imm1), .out_illegal(ill1), .illegal_sticky(sticky1),
    .fifo_count(count1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd);
    return {op, rs1, rs2, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs1, rt, imm};
  endfunction

  function automatic logic [38:0] mk(input logic rt, input logic it, input logic [1:0] alu,
                                     input logic wr, input logic mr, input logic mw,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [15:0] imm,
                                     input logic ill);
    return {rt, it, alu, wr, mr, mw, rd, rs1, rs2, imm, ill};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [38:0] exp_bundle;
    logic        exp_drop0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  q0[$];
    logic [1:0]  q1[$];
    logic [15:0] got[$];
    logic [31:0] drop_seq[4];
    int          seen;

    // Decode table: {name, instr, expected bundle, dropped by dut0}.
    vecs[0] = '{"add",   enc_r(OPC_ADD, 5'd2, 5'd9, 5'd7),
                mk(1, 0, 2'd1, 1, 0, 0, 5'd7, 5'd2, 5'd9, 16'h3800, 0), 1'b0};
    vecs[1] = '{"sub",   enc_r(OPC_SUB, 5'd30, 5'd0, 5'd31),
                mk(1, 0, 2'd2, 1, 0, 0, 5'd31, 5'd30, 5'd0, 16'hF800, 0), 1'b0};
    vecs[2] = '{"addi",  enc_i(OPC_ADDI, 5'd1, 5'd4, 16'h8000),
                mk(0, 1, 2'd1, 1, 0, 0, 5'd4, 5'd1, 5'd4, 16'h8000, 0), 1'b0};
    vecs[3] = '{"load",  enc_i(OPC_LOAD, 5'd3, 5'd10, 16'h0010),
                mk(0, 1, 2'd0, 1, 1, 0, 5'd10, 5'd3, 5'd10, 16'h0010, 0), 1'b0};
    vecs[4] = '{"store", enc_i(OPC_STORE, 5'd8, 5'd6, 16'hFFFC),
                mk(0, 1, 2'd0, 0, 0, 1, 5'd6, 5'd8, 5'd6, 16'hFFFC, 0), 1'b0};
    vecs[5] = '{"nop",   enc_i(OPC_NOP, 5'd1, 5'd2, 16'h1234),
                mk(0, 0, 2'd0, 0, 0, 0, 5'd2, 5'd1, 5'd2, 16'h1234, 0), 1'b1};

    // ---------------- reset state ----------------
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    tick(); tick();
    check("rst_out_valid", out_valid0, 0);
    check("rst_count",     count0, 0);
    check("rst_bundle",    bun0, 0);
    check("rst_in_ready",  in_ready0, 1);
    check("rst_sticky",    sticky0, 0);
    rst = 1'b0;
    tick();

    // ---------------- latency: ADD r3,r1,r2 then ADDI r5,r4,-7 ----------------
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = enc_r(OPC_ADD, 5'd1, 5'd2, 5'd3);
    tick();                                   // edge N: ADD pushed
    in_instr = enc_i(OPC_ADDI, 5'd4, 5'd5, 16'hFFF9);
    check("lat_n1_valid", out_valid0, 0);
    tick();                                   // ADDI pushed, ADD loaded
    in_valid = 1'b0;
    check("lat_add_valid", out_valid0, 1);
    check("lat_add_fields", {rt0, it0, alu0, rd0}, {1'b1, 1'b0, ALU_OP_ADD, 5'd3});
    tick();
    check("lat_addi_valid", out_valid0, 1);
    check("lat_addi_fields", {it0, alu0, rd0, rs10, imm0}, {1'b1, ALU_OP_ADD, 5'd5, 5'd4, 16'hFFF9});
    tick(); tick();
    check("lat_drained", {out_valid0, count0}, 0);

    // ---------------- decode table ----------------
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      tick();
      check({vecs[i].name, "_v1"}, out_valid1, 1);
      check({vecs[i].name, "_b1"}, bun1, vecs[i].exp_bundle);
      check({vecs[i].name, "_v0"}, out_valid0, !vecs[i].exp_drop0);
      if (!vecs[i].exp_drop0) check({vecs[i].name, "_b0"}, bun0, vecs[i].exp_bundle);
      tick(); tick();
    end

    // ---------------- fill, full stall, ordered release with wrap ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = enc_i(OPC_ADDI, 5'd0, 5'(i + 1), 16'(100 + i));
      check($sformatf("fill_ready%0d", i), in_ready0, 1);
      tick();
    end
    check("full_count", count0, 4);
    check("full_in_ready", in_ready0, 0);
    check("full_held", {out_valid0, imm0}, {1'b1, 16'd100});
    tick();
    check("stall_hold", {out_valid0, imm0, count0}, {1'b1, 16'd100, 3'd4});
    // Full FIFO must refuse this instruction even though a pop happens now.
    in_instr = enc_i(OPC_ADDI, 5'd0, 5'd9, 16'd999);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (out_valid0) got.push_back(imm0);
      tick();
      in_valid = 1'b0;
    end
    check("release_n", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check($sformatf("release_order%0d", i), got[i], 16'(100 + i));
    end
    check("release_count", count0, 0);

    // ---------------- NOP dropping: STORE, NOP, NOP, LOAD ----------------
    drop_seq[0] = enc_i(OPC_STORE, 5'd1, 5'd2, 16'h0004);
    drop_seq[1] = enc_i(OPC_NOP,   5'd0, 5'd0, 16'h0000);
    drop_seq[2] = enc_i(OPC_NOP,   5'd0, 5'd0, 16'h0000);
    drop_seq[3] = enc_i(OPC_LOAD,  5'd3, 5'd4, 16'h0008);
    q0.delete(); q1.delete();
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4);
      in_instr = drop_seq[c % 4];
      tick();
      if (out_valid0) q0.push_back({mw0, mr0});
      if (out_valid1) q1.push_back({mw1, mr1});
    end
    in_valid = 1'b0;
    check("drop_n0", q0.size(), 2);
    if (q0.size() == 2) check("drop_seq0", {q0[0], q0[1]}, {2'b10, 2'b01});
    check("drop_n1", q1.size(), 4);
    if (q1.size() == 4) check("drop_seq1", {q1[0], q1[1], q1[2], q1[3]}, 8'b10_00_00_01);

    // ---------------- flush with a push in the same cycle ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = enc_i(OPC_ADDI, 5'd0, 5'd1, 16'(i + 1));
      tick();
    end
    check("pre_flush", {out_valid0, count0}, {1'b1, 3'd2});
    flush = 1'b1; in_instr = enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd4);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("post_flush", {out_valid0, count0}, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid0 || count0 != 0) seen++;
    end
    check("flush_nothing_emerges", seen, 0);

    // ---------------- unknown opcode 0x3F ----------------
    out_ready = 1'b0;
    check("ill_sticky_before", sticky0, 0);
    in_valid = 1'b1; in_instr = 32'hFC00_0000;
    tick();
    in_valid = 1'b0;
    tick();
    check("ill_v0", out_valid0, TRAP);
    check("ill_v1", out_valid1, 1);
    check("ill_b1", bun1, mk(0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 16'h0000, TRAP));
    check("ill_flag0", out_valid0 && ill0, TRAP);
    check("ill_sticky_pre_xfer", sticky0, 0);
    out_ready = 1'b1;
    tick();
    check("ill_sticky_xfer", {sticky0, sticky1}, {TRAP, TRAP});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ill_sticky_flush", sticky0, TRAP);
    tick();

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = enc_r(OPC_ADD, 5'd1, 5'd2, 5'(i + 10));
      tick();
    end
    in_valid = 1'b0;
    check("mid_state", {out_valid0, count0}, {1'b1, 3'd3});
    rst = 1'b1;
    #1;
    check("mid_rst_valid_count", {out_valid0, count0}, 0);
    check("mid_rst_alu", alu0, ALU_OP_NOP);
    check("mid_rst_bundle", bun0, 0);
    check("mid_rst_sticky", sticky0, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_after", {out_valid0, count0, in_ready0}, {1'b0, 3'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
